// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_if
//  Description : Decode / writeback / status bundle for the issue scoreboard.
//                master = decode and writeback side, slave = scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             dec_valid_i;
    logic             dec_ready_o;
    logic [4:0]       dec_rs1_i;
    logic [4:0]       dec_rs2_i;
    logic             dec_use_rs1_i;
    logic             dec_use_rs2_i;
    logic [4:0]       dec_rd_i;
    logic             dec_we_i;
    logic             dec_is_mem_i;
    logic             flush_i;
    logic             issue_o;
    logic             wb_valid_i;
    logic [4:0]       wb_rd_i;
    logic [CNT_W-1:0] inflight_o;
    logic             sb_err_o;
    logic             fwd_rs1_o;
    logic             fwd_rs2_o;

    modport master (
        output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i,
               dec_rd_i, dec_we_i, dec_is_mem_i, flush_i, wb_valid_i, wb_rd_i,
        input  dec_ready_o, issue_o, inflight_o, sb_err_o, fwd_rs1_o, fwd_rs2_o
    );

    modport slave (
        input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i,
               dec_rd_i, dec_we_i, dec_is_mem_i, flush_i, wb_valid_i, wb_rd_i,
        output dec_ready_o, issue_o, inflight_o, sb_err_o, fwd_rs1_o, fwd_rs2_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Issue controller between decode and execute. Keeps an
//                in-order FIFO of in-flight {rd, we, is_mem}, stalls decode on
//                RAW hazards or a full FIFO, retires the head on writeback and
//                flags protocol errors (sticky until reset).
//                Optional feature macro: HAZARD_FORWARDING_EN -- a hazard whose
//                only match is the youngest non-load entry is resolved by EX
//                forwarding instead of a stall.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    hazard_scoreboard_if.slave  bus
);

    localparam int               PTR_W       = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_last  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);

    // FIFO storage; r_valid mirrors occupancy per slot so the hazard compare
    // needs no pointer arithmetic.
    logic [4:0]       r_rd [DEPTH];
    logic [DEPTH-1:0] r_we;
    logic [DEPTH-1:0] r_mem;
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_rp;
    logic [PTR_W-1:0] r_wp;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [DEPTH-1:0] w_match1;
    logic [DEPTH-1:0] w_match2;
    logic             w_stall1;
    logic             w_stall2;
    logic             w_full;
    logic             w_ready;
    logic             w_issue;
    logic             w_pop;
    logic             w_err_set;
    logic             w_push_we;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    // Per-slot RAW compare; we is stored already qualified by rd!=0, so x0
    // destinations never match.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign w_match1[gi] = r_valid[gi] && r_we[gi] && bus.dec_use_rs1_i &&
                              (bus.dec_rs1_i != 5'd0) && (r_rd[gi] == bus.dec_rs1_i);
        assign w_match2[gi] = r_valid[gi] && r_we[gi] && bus.dec_use_rs2_i &&
                              (bus.dec_rs2_i != 5'd0) && (r_rd[gi] == bus.dec_rs2_i);
    end

`ifdef HAZARD_FORWARDING_EN
    logic [PTR_W-1:0] w_young;
    logic [DEPTH-1:0] w_young_oh;
    logic             w_fwd1_ok;
    logic             w_fwd2_ok;

    // Forwarding is safe only when the sole producer is the instruction now in
    // EX (youngest entry) and its result is not coming from memory.
    always_comb begin
        w_young    = (r_wp == '0) ? c_ptr_last : r_wp - 1'b1;
        w_young_oh = {{(DEPTH-1){1'b0}}, 1'b1} << w_young;
        w_fwd1_ok  = (w_match1 == w_young_oh) && !r_mem[w_young];
        w_fwd2_ok  = (w_match2 == w_young_oh) && !r_mem[w_young];
        w_stall1   = (|w_match1) && !w_fwd1_ok;
        w_stall2   = (|w_match2) && !w_fwd2_ok;
    end

    assign bus.fwd_rs1_o = w_fwd1_ok && w_issue;
    assign bus.fwd_rs2_o = w_fwd2_ok && w_issue;
`else
    logic w_unused_mem;

    // Without forwarding every match stalls; is_mem is tracked but not consulted.
    always_comb begin
        w_stall1 = |w_match1;
        w_stall2 = |w_match2;
    end

    assign w_unused_mem  = ^r_mem;
    assign bus.fwd_rs1_o = 1'b0;
    assign bus.fwd_rs2_o = 1'b0;
`endif

    // Ready ignores a same-cycle pop: full or matching-the-popping-entry still stalls.
    always_comb begin
        w_full    = (r_count == c_depth_cnt);
        w_ready   = !w_stall1 && !w_stall2 && !w_full;
        w_issue   = bus.dec_valid_i && w_ready && !bus.flush_i;
        w_push_we = bus.dec_we_i && (bus.dec_rd_i != 5'd0);
        w_pop     = bus.wb_valid_i && (r_count != '0);
        w_err_set = bus.wb_valid_i &&
                    ((r_count == '0) || (r_we[r_rp] && (bus.wb_rd_i != r_rd[r_rp])));
    end

    assign bus.dec_ready_o = w_ready;
    assign bus.issue_o     = w_issue;
    assign bus.inflight_o  = r_count;
    assign bus.sb_err_o    = r_err;

    // FIFO push/pop, occupancy and sticky error state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i] <= 5'd0;
            end
            r_we    <= '0;
            r_mem   <= '0;
            r_valid <= '0;
            r_rp    <= '0;
            r_wp    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_valid[r_rp] <= 1'b0;
                r_rp          <= ptr_inc(r_rp);
            end
            if (w_issue) begin
                r_rd[r_wp]    <= bus.dec_rd_i;
                r_we[r_wp]    <= w_push_we;
                r_mem[r_wp]   <= bus.dec_is_mem_i;
                r_valid[r_wp] <= 1'b1;
                r_wp          <= ptr_inc(r_wp);
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed-vector bench; the driver queues the expected outputs
//                of each cycle, a negedge monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rstn;

    hazard_scoreboard_if #(.DEPTH(DEPTH)) bus_if();

    hazard_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  rdy;
        logic  iss;
        int    infl;
        logic  err;
        logic  f1;
        logic  f2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input string fld, input logic [7:0] act,
                       input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
        end
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "ready",    8'(bus_if.dec_ready_o), 8'(e.rdy));
            chk(e.name, "issue",    8'(bus_if.issue_o),     8'(e.iss));
            chk(e.name, "inflight", 8'(bus_if.inflight_o),  8'(e.infl));
            chk(e.name, "err",      8'(bus_if.sb_err_o),    8'(e.err));
            chk(e.name, "fwd1",     8'(bus_if.fwd_rs1_o),   8'(e.f1));
            chk(e.name, "fwd2",     8'(bus_if.fwd_rs2_o),   8'(e.f2));
        end
    end

    task automatic idle();
        bus_if.dec_valid_i   = 1'b0;
        bus_if.dec_rs1_i     = 5'd0;
        bus_if.dec_rs2_i     = 5'd0;
        bus_if.dec_use_rs1_i = 1'b0;
        bus_if.dec_use_rs2_i = 1'b0;
        bus_if.dec_rd_i      = 5'd0;
        bus_if.dec_we_i      = 1'b0;
        bus_if.dec_is_mem_i  = 1'b0;
        bus_if.flush_i       = 1'b0;
        bus_if.wb_valid_i    = 1'b0;
        bus_if.wb_rd_i       = 5'd0;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we);
        bus_if.dec_valid_i   = 1'b1;
        bus_if.dec_rs1_i     = rs1;
        bus_if.dec_use_rs1_i = u1;
        bus_if.dec_rs2_i     = rs2;
        bus_if.dec_use_rs2_i = u2;
        bus_if.dec_rd_i      = rd;
        bus_if.dec_we_i      = we;
    endtask

    task automatic wb(input logic [4:0] rd);
        bus_if.wb_valid_i = 1'b1;
        bus_if.wb_rd_i    = rd;
    endtask

    // Queue this cycle's expectation, advance one clock, return inputs to idle.
    task automatic step(input string nm, input logic rdy, input logic iss, input int infl,
                        input logic err, input logic f1 = 1'b0, input logic f2 = 1'b0);
        exp_t e;
        e.name = nm; e.rdy = rdy; e.iss = iss; e.infl = infl;
        e.err = err; e.f1 = f1; e.f2 = f2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step("reset", 1, 0, 0, 0);
        rstn = 1'b1;

        // RAW on rs1 against an in-flight writer
        dec(0, 1, 0, 0, 5, 1);            step("raw_a", 1, 1, 0, 0);
`ifdef HAZARD_FORWARDING_EN
        dec(5, 1, 0, 0, 6, 1);            step("raw_fwd", 1, 1, 1, 0, 1, 0);
        wb(5);                            step("raw_wb5", 1, 0, 2, 0);
        wb(6);                            step("raw_wb6", 1, 0, 1, 0);
`else
        dec(5, 1, 0, 0, 6, 1);            step("raw_stall", 0, 0, 1, 0);
        dec(5, 1, 0, 0, 6, 1); wb(5);     step("raw_stall_pop", 0, 0, 1, 0);
        dec(5, 1, 0, 0, 6, 1);            step("raw_go", 1, 1, 0, 0);
        wb(6);                            step("raw_wb6", 1, 0, 1, 0);
`endif

        // Fill to DEPTH, full-with-pop stays not ready, then flush
        dec(0, 0, 0, 0, 1, 1);            step("fill1", 1, 1, 0, 0);
        dec(0, 0, 0, 0, 2, 1);            step("fill2", 1, 1, 1, 0);
        dec(0, 0, 0, 0, 3, 1);            step("fill3", 1, 1, 2, 0);
        dec(0, 0, 0, 0, 4, 1);            step("fill4", 1, 1, 3, 0);
        dec(0, 0, 0, 0, 9, 1);            step("full", 0, 0, 4, 0);
        dec(0, 0, 0, 0, 9, 1); wb(1);     step("full_pop", 0, 0, 4, 0);
        dec(0, 0, 0, 0, 9, 1); bus_if.flush_i = 1'b1;
                                          step("flush", 1, 0, 3, 0);
        step("after_flush", 1, 0, 3, 0);

        // Push+pop at occupancy 2 across pointer wrap, order preserved
        wb(2);                            step("drain2", 1, 0, 3, 0);
        dec(0, 0, 0, 0, 10, 1); wb(3);    step("pp_a", 1, 1, 2, 0);
        dec(0, 0, 0, 0, 11, 1); wb(4);    step("pp_b", 1, 1, 2, 0);
        dec(10, 1, 0, 0, 12, 0); wb(10);  step("wrap_haz", 0, 0, 2, 0);
        dec(10, 1, 0, 0, 12, 0); wb(11);  step("wrap_go", 1, 1, 1, 0);
        wb(0);                            step("wb_nowrite", 1, 0, 1, 0);
        step("wrap_empty", 1, 0, 0, 0);

        // x0 never creates a hazard; non-writer head ignores wb_rd
        dec(0, 1, 0, 1, 0, 1);            step("nop_push", 1, 1, 0, 0);
        dec(0, 1, 0, 1, 3, 1);            step("x0_src", 1, 1, 1, 0);
        wb(7);                            step("wb_nop", 1, 0, 2, 0);
        wb(3);                            step("wb_x3", 1, 0, 1, 0);
        step("x0_empty", 1, 0, 0, 0);

        // rs2 hazard against an older writer, and use flag gating it
        dec(0, 0, 0, 0, 8, 1);            step("rs2_a", 1, 1, 0, 0);
        dec(0, 0, 0, 0, 9, 1);            step("rs2_b", 1, 1, 1, 0);
        dec(0, 0, 8, 1, 13, 1);           step("rs2_stall", 0, 0, 2, 0);
        dec(0, 0, 8, 0, 13, 1);           step("rs2_unused", 1, 1, 2, 0);
        wb(8);                            step("rs2_wb8", 1, 0, 3, 0);
        wb(9);                            step("rs2_wb9", 1, 0, 2, 0);
        wb(13);                           step("rs2_wb13", 1, 0, 1, 0);
        step("rs2_empty", 1, 0, 0, 0);

        // Pop while empty sets the sticky error
        wb(0);                            step("empty_pop", 1, 0, 0, 0);
        step("err_set", 1, 0, 0, 1);
        step("err_sticky", 1, 0, 0, 1);

        // Reset mid-run with three entries in flight
        dec(0, 0, 0, 0, 1, 1);            step("rr1", 1, 1, 0, 1);
        dec(0, 0, 0, 0, 2, 1);            step("rr2", 1, 1, 1, 1);
        dec(0, 0, 0, 0, 3, 1);            step("rr3", 1, 1, 2, 1);
        step("rr_hold", 1, 0, 3, 1);
        rstn = 1'b0;                      step("midrun_rst", 1, 0, 0, 0);
        step("midrun_rst2", 1, 0, 0, 0);
        rstn = 1'b1;

        // Writeback rd mismatch against head.rd
        dec(0, 0, 0, 0, 5, 1);            step("mm_push", 1, 1, 0, 0);
        wb(7);                            step("mm_pop", 1, 0, 1, 0);
        step("mm_err", 1, 0, 0, 1);
        step("mm_sticky", 1, 0, 0, 1);

        repeat (2) @(posedge clk);
        chk("drain", "queue_left", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
